// File: rtl/cache_fill_controller.sv
// Cache miss fill sequencer: fetches one block word-by-word over req/ack,
// writes each word into the selected way/word register, then strobes tag/valid.
module cache_fill_controller #(
  parameter int WORDS  = 4,
  parameter int WAYS   = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     miss,
  input  logic [ADDR_W-1:0]        missAddr,
  input  logic [$clog2(WAYS)-1:0]  victimWay,
  output logic                     memReq,
  output logic [ADDR_W-1:0]        memAddr,
  input  logic                     memAck,
  input  logic [DATA_W-1:0]        memData,
  output logic                     regWrite,
  output logic [WAYS-1:0]          decOutWay,
  output logic [WORDS-1:0]         decOutWord,
  output logic [DATA_W-1:0]        writeData,
  output logic                     tagWrite,
  output logic [ADDR_W-1:0]        blockAddr,
  output logic                     busy,
  output logic                     fillDone
);

  localparam int CNT_W = $clog2(WORDS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int OFF_W = CNT_W + 2;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS - 1);

  typedef enum logic [2:0] {IDLE, REQ, WRITE, TAG, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [WAY_W-1:0]    way_q, way_d;
  logic [ADDR_W-1:0]   block_addr_q, block_addr_d, miss_block;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic [WAYS-1:0]     dec_way_q, dec_way_d;
  logic [WORDS-1:0]    dec_word_q, dec_word_d;
  logic                mem_req_q, mem_req_d;
  logic                reg_write_q, reg_write_d;
  logic                tag_write_q, tag_write_d;
  logic                busy_q, busy_d;
  logic                fill_done_q, fill_done_d;

  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign miss_block = missAddr & ~OFF_MASK;

  // Outputs are registered from the next-state decode, so each output register
  // already holds the value belonging to the state being entered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    way_d        = way_q;
    block_addr_d = block_addr_q;
    mem_addr_d   = mem_addr_q;
    write_data_d = write_data_q;
    dec_way_d    = '0;
    dec_word_d   = '0;
    mem_req_d    = 1'b0;
    reg_write_d  = 1'b0;
    tag_write_d  = 1'b0;
    busy_d       = 1'b0;
    fill_done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss) begin
          block_addr_d = miss_block;
          mem_addr_d   = miss_block;
          way_d        = victimWay;
          cnt_d        = '0;
          mem_req_d    = 1'b1;
          busy_d       = 1'b1;
          state_d      = REQ;
        end
      end
      REQ: begin
        busy_d = 1'b1;
        if (memAck) begin
          write_data_d = memData;
          reg_write_d  = 1'b1;
          dec_way_d    = WAYS'(1) << way_q;
          dec_word_d   = WORDS'(1) << cnt_q;
          state_d      = WRITE;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      WRITE: begin
        busy_d = 1'b1;
        if (cnt_q == LAST_WORD) begin
          tag_write_d = 1'b1;
          dec_way_d   = WAYS'(1) << way_q;
          state_d     = TAG;
        end else begin
          cnt_d      = cnt_inc;
          mem_req_d  = 1'b1;
          // Word offset is OR-ed into the aligned base, so it never carries into tag bits.
          mem_addr_d = block_addr_q | ADDR_W'({cnt_inc, 2'b00});
          state_d    = REQ;
        end
      end
      TAG: begin
        busy_d      = 1'b1;
        fill_done_d = 1'b1;
        state_d     = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      way_q        <= '0;
      block_addr_q <= '0;
      mem_addr_q   <= '0;
      write_data_q <= '0;
      dec_way_q    <= '0;
      dec_word_q   <= '0;
      mem_req_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      tag_write_q  <= 1'b0;
      busy_q       <= 1'b0;
      fill_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      way_q        <= way_d;
      block_addr_q <= block_addr_d;
      mem_addr_q   <= mem_addr_d;
      write_data_q <= write_data_d;
      dec_way_q    <= dec_way_d;
      dec_word_q   <= dec_word_d;
      mem_req_q    <= mem_req_d;
      reg_write_q  <= reg_write_d;
      tag_write_q  <= tag_write_d;
      busy_q       <= busy_d;
      fill_done_q  <= fill_done_d;
    end
  end

  assign memReq     = mem_req_q;
  assign memAddr    = mem_addr_q;
  assign regWrite   = reg_write_q;
  assign decOutWay  = dec_way_q;
  assign decOutWord = dec_word_q;
  assign writeData  = write_data_q;
  assign tagWrite   = tag_write_q;
  assign blockAddr  = block_addr_q;
  assign busy       = busy_q;
  assign fillDone   = fill_done_q;

endmodule

// File: doc/cache_fill_controller.md
Name: cache_fill_controller

Overview:
- Miss-handling fill sequencer that feeds the cache data array (banks of 32-bit word registers).
- On a miss it fetches one block from next-level memory, one word at a time, over a req/ack handshake.
- Each fetched word is written into the chosen way/word register using write-enable, one-hot way select and one-hot word select.
- After the last data word it issues a tag/valid write strobe, then signals completion to the cache control FSM.

Parameters:
- WORDS, 4, data words per block; power of 2, at least 2.
- WAYS, 4, associativity; power of 2, at least 2.
- DATA_W, 32, word width; equals memory data width.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- miss  in  1  fill request; sampled only in IDLE.
- missAddr  in  ADDR_W  byte address of the missing access.
- victimWay  in  log2(WAYS)  way to fill; sampled with miss.
- memReq  out  1  memory read request.
- memAddr  out  ADDR_W  word-aligned address of the requested word.
- memAck  in  1  memory data valid; qualifies memData.
- memData  in  DATA_W  returned word.
- regWrite  out  1  data-array write enable.
- decOutWay  out  WAYS  one-hot way select; all zero when regWrite=0 and tagWrite=0.
- decOutWord  out  WORDS  one-hot word select; all zero when regWrite=0.
- writeData  out  DATA_W  word to write.
- tagWrite  out  1  tag/valid write strobe for {decOutWay, blockAddr}.
- blockAddr  out  ADDR_W  latched block base address.
- busy  out  1  fill in progress.
- fillDone  out  1  one-cycle completion pulse.

Behaviour:
- All outputs are driven from registers (Moore); no combinational path from inputs to outputs.
- Reset (reset=1 at a clk edge):
  - state=IDLE, word counter=0.
  - All outputs 0, including writeData, memAddr and blockAddr.
  - Reset takes priority over every other input.
- States: IDLE, REQ, WRITE, TAG, DONE.
- IDLE:
  - busy=0.
  - If miss=1: latch blockAddr = missAddr with low log2(WORDS)+2 bits cleared, latch victimWay, counter=0, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - busy=1, memReq=1, memAddr = blockAddr + 4*counter.
  - memAddr is held stable while waiting.
  - If memAck=1: capture memData into writeData, go to WRITE.
  - Otherwise stay in REQ; unlimited wait states allowed.
- WRITE (exactly one cycle):
  - regWrite=1, memReq=0.
  - decOutWay = one-hot(way), decOutWord = one-hot(counter), writeData held.
  - If counter = WORDS-1: go to TAG.
  - Otherwise counter+1, go to REQ.
- TAG (one cycle): tagWrite=1, decOutWay = one-hot(way), go to DONE.
- DONE (one cycle): fillDone=1, busy=1, go to IDLE.
- Ignored inputs:
  - miss while not in IDLE is ignored; it is not queued.
  - memAck outside REQ is ignored.
  - missAddr and victimWay changes after the accept cycle have no effect.
- Latency, with memAck=1 in every REQ cycle and counting miss-sample edge = cycle 0:
  - regWrite high in cycles 2, 4, ..., 2*WORDS.
  - tagWrite high in cycle 2*WORDS+1.
  - fillDone high in cycle 2*WORDS+2.
  - busy high in cycles 1 through 2*WORDS+2.
- Each wait-state cycle in REQ delays all later events by one cycle.
- Back-to-back fills: a miss can be accepted in the first IDLE cycle after DONE. Minimum gap between fills is one cycle.
- Counter wrap: the counter never exceeds WORDS-1; it is cleared on accept.
- Reset mid-fill:
  - Abort immediately and return to IDLE with outputs cleared.
  - The partially written block gets no tagWrite, so it stays invalid.
- Address wrap: blockAddr + 4*counter never crosses the block boundary; no carry into tag bits.

Test Plan:
1. Basic fill, WORDS=4, zero-wait memory:
   - Stimulus: reset, then miss=1, missAddr=0x00001234, victimWay=2, memAck held at 1.
   - memAddr = 0x1230, 0x1234, 0x1238, 0x123C in successive REQ cycles.
   - regWrite in cycles 2/4/6/8 with decOutWord 0001/0010/0100/1000 and decOutWay=0100.
   - writeData equals memData; tagWrite in cycle 9, fillDone in cycle 10, blockAddr=0x1230.
2. Wait states:
   - Stimulus: memAck delayed 3 cycles for word 1 only.
   - memReq and memAddr=0x1234 held for 4 cycles.
   - fillDone arrives in cycle 13; no regWrite while waiting.
3. Miss while busy:
   - Stimulus: pulse miss with missAddr=0x8000 in cycle 3 of a fill to 0x1230.
   - Fill completes to 0x1230 only; 0x8000 is never requested; busy drops after fillDone.
4. Reset mid-fill:
   - Stimulus: assert reset in cycle 5 (after 2 words written).
   - Next cycle: all outputs 0, state IDLE, no tagWrite, no fillDone.
   - A new miss to 0x40 then fills 0x40–0x4C normally.
5. Back-to-back fills:
   - Stimulus: miss held at 1 continuously, way 0 then way 3.
   - Second fill accepted in the first IDLE cycle after fillDone.
   - Second fill uses decOutWay=1000 and the new blockAddr.
6. Spurious ack:
   - Stimulus: memAck=1 with memData=0xDEADBEEF while in IDLE and during WRITE.
   - No regWrite, and writeData is unaffected outside REQ capture.
